uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  UART receiver: the downstream peer of the UART transmitter. Recovers 8N1 frames
//  (or 8E1/8O1 with parity enabled) from the serial line. The line is driven by the
//  transmitter's DATAo output or by an external pin.
//  Presents each received word on a valid/ready holding register.
//  Flags frame, overrun and (optionally) parity errors.
// PARAMETERS
//  FREQ_CLK    100000000  clock frequency in Hz
//  DATA_WDTH   8          data bits per frame, LSB first
//  PARITY_ODD  0          with UART_RX_PARITY_EN: 0 = even parity, 1 = odd parity
// PORTS
//  CLKip        in   1          clock
//  rst          in   1          reset: synchronous, active-high
//  RXi          in   1          serial line (asynchronous); idle is high
//  BAUD_RATEi   in   32         baud rate in bit/s
//  RDYi         in   1          consumer accepts DATAo while VALIDo=1
//  DATAo        out  DATA_WDTH  last good received word
//  VALIDo       out  1          DATAo holds an unconsumed word
//  BUSYo        out  1          frame in progress (any state other than IDLE)
//  FRAME_ERRo   out  1          1-cycle pulse: stop bit sampled low
//  OVERRUNo     out  1          1-cycle pulse: good word dropped because VALIDo was 1
//  PARITY_ERRo  out  1          1-cycle pulse: parity mismatch (UART_RX_PARITY_EN only)
// BEHAVIOUR
//  - Interface: reset rst, synchronous, active-high; clock CLKip.
//  - Reset: all outputs are 0, FSM goes to IDLE, and counters clear. Reset mid-frame
//    abandons the frame on the next edge; no error pulse is produced.
//  - RXi passes through a 2-FF synchronizer (rx_s). All decisions use rx_s.
//  - Bit period: N = FREQ_CLK / BAUD_RATEi, in 32-bit unsigned arithmetic.
//    N is latched on entry to START and held for the whole frame.
//  - If BAUD_RATEi == 0 or N < 4, the FSM stays in IDLE and ignores the line.
//  - FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE, plus BREAK.
//    IDLE:   a high-to-low transition on rx_s -> START, with clk_count = 0.
//    START:  at clk_count == N/2 - 1 (mid start bit), sample rx_s.
//            If rx_s == 1 -> IDLE (false start; no flags).
//            If rx_s == 0 -> DATA, with clk_count = 0.
//    DATA:   sample at every clk_count == N-1 (mid-bit), shifting the bit in LSB first.
//            After DATA_WDTH samples -> PARITY if enabled, else STOP.
//    PARITY: sample one bit at mid-bit and compare it with the computed parity -> STOP.
//    STOP:   sample at mid stop bit.
//            If rx_s == 1 -> IDLE immediately. This mid-bit exit allows back-to-back
//            frames.
//            If rx_s == 0 -> FRAME_ERRo pulse and go to BREAK.
//    BREAK:  wait for rx_s == 1, then go to IDLE. This avoids a false start during a
//            break condition.
//  - Commit, on the cycle after the stop-bit sample:
//    Good word = stop bit high and no parity error.
//    Good word and VALIDo = 0: DATAo is loaded and VALIDo is set.
//    Good word and VALIDo = 1: OVERRUNo pulses; DATAo and VALIDo are unchanged.
//    Errored words never load DATAo.
//  - Handshake: VALIDo clears on the edge where VALIDo & RDYi.
//    If a commit coincides with that acceptance, the new word loads and VALIDo stays 1.
//    There is no overrun in that case.
//  - Latency: VALIDo rises about (1 + DATA_WDTH + 0.5)·N + 4 clocks after the RXi
//    falling edge. That is 2 synchronizer cycles, 1 edge-detect cycle and 1 commit cycle.
//  - A change on BAUD_RATEi mid-frame has no effect until the next START.
// CONFIGURATION
//  - UART_RX_PARITY_EN defined:
//    The PARITY state is present and the frame is 1+DATA_WDTH+1+1 bits.
//    PARITY_ERRo pulses on the commit cycle of a mismatching frame.
//    A frame with both a parity error and a frame error pulses both flags.
//  - UART_RX_PARITY_EN undefined:
//    There is no PARITY state and no PARITY_ERRo port.
//    The frame is 8N1-style, and PARITY_ODD is ignored.
// TESTING
//  (FREQ_CLK=100e6, BAUD_RATEi=1_000_000, so N=100. Stimulus is generated
//  independently or by the UART transmitter.)
//  1. Send 0xA5 with RDYi=1. DATAo=0xA5 and VALIDo=1 for exactly 1 cycle, rising
//     950+/-5 clocks after the start edge. BUSYo=0 afterwards.
//  2. Drive a 30-clock low glitch on idle RXi. There is no VALIDo and no error flags.
//     BUSYo pulses and then returns to 0 after about 50 clocks.
//  3. Send 0x5A with the stop bit forced low, followed by 2000 clocks of line low.
//     FRAME_ERRo pulses once and VALIDo stays 0.
//     After the line returns high, 0x81 is received correctly.
//  4. With RDYi=0, send 0x3C then 0xC3 back-to-back.
//     DATAo=0x3C, VALIDo=1 and OVERRUNo pulses once.
//     Then set RDYi=1 for 1 cycle: VALIDo goes to 0.
//  5. Assert rst at the mid-point of data bit 4 of 0xFF.
//     All outputs go to 0, with no flags.
//     A following 0x12 frame is received correctly.
//  6. [UART_RX_PARITY_EN, PARITY_ODD=0] Send 0x07 with a parity bit of 0, then with a
//     parity bit of 1.
//     Parity bit 0 (wrong): PARITY_ERRo pulses and there is no VALIDo.
//     Parity bit 1 (correct): DATAo=0x07 and VALIDo=1.

Source files
------------

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - received-word holding register handshake (DATAo/VALIDo/RDYi).
interface uart_rx_if #(
  parameter int DATA_WDTH = 8
) ();
  logic [DATA_WDTH-1:0] DATAo;
  logic                 VALIDo;
  logic                 RDYi;

  modport master (output DATAo, output VALIDo, input RDYi);
  modport slave  (input DATAo, input VALIDo, output RDYi);
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver (8N1, or 8E1/8O1 when UART_RX_PARITY_EN is defined).
// Word is presented on a valid/ready holding register; frame/overrun/parity errors pulse.
module uart_rx #(
  parameter int unsigned FREQ_CLK   = 100000000,
  parameter int          DATA_WDTH  = 8,
  parameter int          PARITY_ODD = 0
) (
  input  logic        CLKip,
  input  logic        rst,
  input  logic        RXi,
  input  logic [31:0] BAUD_RATEi,
  uart_rx_if.master   rx_if,
  output logic        BUSYo,
  output logic        FRAME_ERRo,
  output logic        OVERRUNo
`ifdef UART_RX_PARITY_EN
  ,
  output logic        PARITY_ERRo
`endif
);
  localparam int BCW = $clog2(DATA_WDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3,
    S_BREAK  = 3'd4
`ifdef UART_RX_PARITY_EN
    ,
    S_PARITY = 3'd5
`endif
  } state_t;

  state_t               state_q, state_d;
  logic                 rx_meta_q, rx_s_q, rx_prev_q;
  logic [31:0]          n_q, n_d, cnt_q, cnt_d;
  logic [BCW-1:0]       bit_q, bit_d;
  logic [DATA_WDTH-1:0] shift_q, shift_d, data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 commit_q, commit_d, stop_ok_q, stop_ok_d, par_ok_q, par_ok_d;
  logic                 fe_q, fe_d, ov_q, ov_d;
  logic [31:0]          n_calc;
  logic                 baud_ok, mid_start, mid_bit, accept;

  // A zero baud rate would divide by zero; it maps to N=0 and is rejected with short periods.
  assign n_calc    = (BAUD_RATEi == 32'd0) ? 32'd0 : FREQ_CLK / BAUD_RATEi;
  assign baud_ok   = (n_calc >= 32'd4);
  assign mid_start = (cnt_q == (n_q >> 1) - 32'd1);
  assign mid_bit   = (cnt_q == n_q - 32'd1);

`ifdef UART_RX_PARITY_EN
  localparam logic PAR_ODD_BIT = (PARITY_ODD != 0);
  logic pe_q, pe_d;
  assign PARITY_ERRo = pe_q;
`else
  logic unused_parity_odd;
  assign unused_parity_odd = (PARITY_ODD != 0);
`endif

  always_ff @(posedge CLKip) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
      n_q       <= '0;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      commit_q  <= 1'b0;
      stop_ok_q <= 1'b0;
      par_ok_q  <= 1'b1;
      fe_q      <= 1'b0;
      ov_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pe_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      rx_meta_q <= RXi;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
      n_q       <= n_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      commit_q  <= commit_d;
      stop_ok_q <= stop_ok_d;
      par_ok_q  <= par_ok_d;
      fe_q      <= fe_d;
      ov_q      <= ov_d;
`ifdef UART_RX_PARITY_EN
      pe_q      <= pe_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    cnt_d     = cnt_q + 32'd1;
    bit_d     = bit_q;
    shift_d   = shift_q;
    commit_d  = 1'b0;
    stop_ok_d = stop_ok_q;
    par_ok_d  = par_ok_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (baud_ok && rx_prev_q && !rx_s_q) begin
          state_d  = S_START;
          n_d      = n_calc;
          par_ok_d = 1'b1;
        end
      end
      S_START: if (mid_start) begin
        cnt_d   = '0;
        bit_d   = '0;
        state_d = rx_s_q ? S_IDLE : S_DATA;
      end
      S_DATA: if (mid_bit) begin
        cnt_d   = '0;
        shift_d = {rx_s_q, shift_q[DATA_WDTH-1:1]};
        bit_d   = bit_q + 1'b1;
        if (bit_q == BCW'(DATA_WDTH - 1)) begin
`ifdef UART_RX_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: if (mid_bit) begin
        cnt_d    = '0;
        par_ok_d = (rx_s_q == ((^shift_q) ^ PAR_ODD_BIT));
        state_d  = S_STOP;
      end
`endif
      // Leave at mid stop bit so a back-to-back start edge is not missed.
      S_STOP: if (mid_bit) begin
        cnt_d     = '0;
        commit_d  = 1'b1;
        stop_ok_d = rx_s_q;
        state_d   = rx_s_q ? S_IDLE : S_BREAK;
      end
      S_BREAK: begin
        cnt_d = '0;
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    fe_d    = 1'b0;
    ov_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    pe_d    = 1'b0;
`endif
    accept  = valid_q & rx_if.RDYi;
    if (accept) valid_d = 1'b0;
    if (commit_q) begin
      fe_d = !stop_ok_q;
`ifdef UART_RX_PARITY_EN
      pe_d = !par_ok_q;
`endif
      // An acceptance on the same edge frees the register, so no overrun then.
      if (stop_ok_q && par_ok_q) begin
        if (valid_q && !accept) begin
          ov_d = 1'b1;
        end else begin
          data_d  = shift_q;
          valid_d = 1'b1;
        end
      end
    end
    BUSYo        = (state_q != S_IDLE);
    FRAME_ERRo   = fe_q;
    OVERRUNo     = ov_q;
    rx_if.DATAo  = data_q;
    rx_if.VALIDo = valid_q;
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - randomized bench for uart_rx against a frame-timing/holding-register model.
`timescale 1ns/1ps
module tb_uart_rx;
  localparam int DW = 8;
`ifdef UART_RX_PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif

  logic        CLKip = 1'b0;
  logic        rst = 1'b1;
  logic        RXi = 1'b1;
  logic [31:0] BAUD_RATEi = 32'd1000000;
  logic        BUSYo, FRAME_ERRo, OVERRUNo;
`ifdef UART_RX_PARITY_EN
  logic        PARITY_ERRo;
`endif
  logic        rdy_dir = 1'b0, rdy_rand = 1'b0, rdy_rand_en = 1'b0;

  uart_rx_if #(.DATA_WDTH(DW)) rx_if ();
  assign rx_if.RDYi = rdy_rand_en ? rdy_rand : rdy_dir;

  uart_rx #(.FREQ_CLK(100000000), .DATA_WDTH(DW), .PARITY_ODD(0)) dut (
    .CLKip      (CLKip),
    .rst        (rst),
    .RXi        (RXi),
    .BAUD_RATEi (BAUD_RATEi),
    .rx_if      (rx_if),
    .BUSYo      (BUSYo),
    .FRAME_ERRo (FRAME_ERRo),
    .OVERRUNo   (OVERRUNo)
`ifdef UART_RX_PARITY_EN
    ,
    .PARITY_ERRo(PARITY_ERRo)
`endif
  );

  always #5 CLKip = ~CLKip;

  typedef struct {
    int          cyc;
    logic [DW-1:0] data;
    bit          stop_ok;
    bit          par_ok;
  } exp_t;

  exp_t          pq[$];
  int            cyc = 0;
  int            total = 0, bad = 0;
  logic          m_valid = 1'b0;
  logic [DW-1:0] m_data = '0;
  bit            e_fe = 0, e_ov = 0, e_pe = 0;
  int            fe_seen = 0, ov_seen = 0, pe_seen = 0, valid_cycles = 0, last_rise = -1;
  bit            prev_v = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: each frame commits at a cycle fixed by the sampling rules; the holding register follows valid/ready.
  always begin
    exp_t e;
    bit   acc, good, rdy;
    @(posedge CLKip);
    cyc++;
    rdy = rx_if.RDYi;
    e_fe = 0; e_ov = 0; e_pe = 0;
    if (rst) begin
      m_valid = 1'b0;
      m_data  = '0;
      pq.delete();
    end else begin
      acc = m_valid && rdy;
      if (acc) m_valid = 1'b0;
      if (pq.size() > 0 && pq[0].cyc == cyc) begin
        e    = pq.pop_front();
        good = e.stop_ok && e.par_ok;
        e_fe = !e.stop_ok;
        e_pe = !e.par_ok;
        if (good) begin
          if (m_valid) e_ov = 1;
          else begin
            m_data  = e.data;
            m_valid = 1'b1;
          end
        end
      end
    end
    @(negedge CLKip);
    check("valid", rx_if.VALIDo, m_valid);
    check("data", rx_if.DATAo, m_data);
    check("frame_err", FRAME_ERRo, e_fe);
    check("overrun", OVERRUNo, e_ov);
`ifdef UART_RX_PARITY_EN
    check("parity_err", PARITY_ERRo, e_pe);
    if (PARITY_ERRo === 1'b1) pe_seen++;
`endif
    if (FRAME_ERRo === 1'b1) fe_seen++;
    if (OVERRUNo === 1'b1) ov_seen++;
    if (rx_if.VALIDo === 1'b1) begin
      valid_cycles++;
      if (!prev_v) last_rise = cyc;
    end
    prev_v = (rx_if.VALIDo === 1'b1);
  end

  always begin
    @(posedge CLKip);
    #1 rdy_rand = 1'($urandom_range(0, 1));
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLKip);
    #1;
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input bit stop, input bit par_flip,
                            input int n, input bit expect_rx, input bit scramble);
    exp_t e;
    if (expect_rx) begin
      e.cyc     = cyc + 4 + n / 2 + (DW + 1 + PBITS) * n;
      e.data    = d;
      e.stop_ok = stop;
      e.par_ok  = !par_flip;
      pq.push_back(e);
    end
    RXi = 1'b0;
    tick(n);
    if (scramble) BAUD_RATEi = $urandom;
    for (int i = 0; i < DW; i++) begin
      RXi = d[i];
      tick(n);
    end
`ifdef UART_RX_PARITY_EN
    RXi = (^d) ^ par_flip;
    tick(n);
`endif
    RXi = stop;
    tick(n);
  endtask

  initial begin
    int k, v0, f0, o0, p0;
    int nt[8];
    int bt[8];
    nt = '{4, 5, 16, 20, 50, 100, 2, 0};
    bt = '{25000000, 20000000, 6250000, 5000000, 2000000, 1000000, 40000000, 0};
    tick(3);
    rst = 1'b0;
    tick(5);
    check("reset_busy", BUSYo, 0);
    check("reset_valid", rx_if.VALIDo, 0);

    rdy_dir = 1'b1;
    k = cyc; v0 = valid_cycles;
    send_frame(8'hA5, 1, 0, 100, 1, 0);
    check("t1_latency", last_rise - k, 954 + 100 * PBITS);
    check("t1_data", rx_if.DATAo, 8'hA5);
    check("t1_valid_len", valid_cycles - v0, 1);
    check("t1_busy_after", BUSYo, 0);

    tick(20);
    v0 = valid_cycles; f0 = fe_seen;
    RXi = 1'b0;
    tick(20);
    check("t2_busy_glitch", BUSYo, 1);
    tick(10);
    RXi = 1'b1;
    tick(30);
    check("t2_busy_end", BUSYo, 0);
    check("t2_no_valid", valid_cycles - v0, 0);
    check("t2_no_fe", fe_seen - f0, 0);

    f0 = fe_seen; v0 = valid_cycles;
    send_frame(8'h5A, 0, 0, 100, 1, 0);
    tick(2000);
    check("t3_busy_break", BUSYo, 1);
    RXi = 1'b1;
    tick(20);
    check("t3_fe_once", fe_seen - f0, 1);
    check("t3_no_valid", valid_cycles - v0, 0);
    send_frame(8'h81, 1, 0, 100, 1, 0);
    tick(5);
    check("t3_data", rx_if.DATAo, 8'h81);

    rdy_dir = 1'b0;
    o0 = ov_seen;
    send_frame(8'h3C, 1, 0, 100, 1, 0);
    send_frame(8'hC3, 1, 0, 100, 1, 0);
    tick(10);
    check("t4_data", rx_if.DATAo, 8'h3C);
    check("t4_valid", rx_if.VALIDo, 1);
    check("t4_ov_once", ov_seen - o0, 1);
    rdy_dir = 1'b1;
    tick(1);
    rdy_dir = 1'b0;
    check("t4_valid_clr", rx_if.VALIDo, 0);

    rdy_dir = 1'b1;
    f0 = fe_seen; o0 = ov_seen;
    RXi = 1'b0;
    tick(100);
    RXi = 1'b1;
    tick(450);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    check("t5_busy", BUSYo, 0);
    check("t5_data", rx_if.DATAo, 0);
    check("t5_valid", rx_if.VALIDo, 0);
    tick(600);
    check("t5_no_flags", (fe_seen - f0) + (ov_seen - o0), 0);
    send_frame(8'h12, 1, 0, 100, 1, 0);
    tick(5);
    check("t5_data_after", rx_if.DATAo, 8'h12);

`ifdef UART_RX_PARITY_EN
    p0 = pe_seen; v0 = valid_cycles;
    send_frame(8'h07, 1, 1, 100, 1, 0);
    tick(5);
    check("t6_pe_once", pe_seen - p0, 1);
    check("t6_no_valid", valid_cycles - v0, 0);
    send_frame(8'h07, 1, 0, 100, 1, 0);
    tick(5);
    check("t6_data", rx_if.DATAo, 8'h07);
    check("t6_valid_once", valid_cycles - v0, 1);
`endif

    v0 = valid_cycles;
    BAUD_RATEi = 32'd0;
    send_frame(8'h55, 1, 0, 100, 0, 0);
    tick(10);
    BAUD_RATEi = 32'd40000000;
    send_frame(8'h55, 1, 0, 20, 0, 0);
    tick(10);
    check("t7_ignored", valid_cycles - v0, 0);
    BAUD_RATEi = 32'd25000000;
    send_frame(8'hC6, 1, 0, 4, 1, 0);
    tick(5);
    check("t7_n4_data", rx_if.DATAo, 8'hC6);
    BAUD_RATEi = 32'd1000000;
    send_frame(8'h96, 1, 0, 100, 1, 1);
    BAUD_RATEi = 32'd1000000;
    tick(5);
    check("t8_baud_change", rx_if.DATAo, 8'h96);

    rdy_rand_en = 1'b1;
    for (int it = 0; it < 40; it++) begin
      int  sel, n;
      bit  ok, stop, flip;
      sel = $urandom_range(0, 7);
      ok = (sel < 6);
      n = ok ? nt[sel] : 20;
      BAUD_RATEi = bt[sel];
      stop = ($urandom_range(0, 7) != 0);
      flip = 0;
`ifdef UART_RX_PARITY_EN
      flip = ($urandom_range(0, 5) == 0);
`endif
      send_frame(8'($urandom), stop, flip, n, ok, ok && ($urandom_range(0, 3) == 0));
      BAUD_RATEi = bt[sel];
      RXi = 1'b1;
      tick(4 + $urandom_range(0, 2 * n));
    end
    tick(50);
    rdy_rand_en = 1'b0;
    check("queue_drained", pq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
